// File: rtl/run_host_if.sv
// Host-side run controller bus: load stream, core handshake, data-memory port, result stream, status.
interface run_host_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 16
);
  logic          start;
  logic [AW-1:0] rd_base;
  logic [AW:0]   rd_len;

  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;

  logic          core_hold;
  logic          core_req;
  logic          core_done;

  logic          mem_sel;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;

  logic          busy;
  logic          fin;
  logic          timed_out;
  logic [CW-1:0] cycle_count;

  // Controller side
  modport master (
    input  start, rd_base, rd_len,
    input  ld_valid, ld_addr, ld_data, ld_last,
    input  core_done, mem_rdata, out_ready,
    output ld_ready, core_hold, core_req,
    output mem_sel, mem_wr_en, mem_addr, mem_wdata,
    output out_valid, out_data, out_last,
    output busy, fin, timed_out, cycle_count
  );

  // Host / core / memory side
  modport slave (
    output start, rd_base, rd_len,
    output ld_valid, ld_addr, ld_data, ld_last,
    output core_done, mem_rdata, out_ready,
    input  ld_ready, core_hold, core_req,
    input  mem_sel, mem_wr_en, mem_addr, mem_wdata,
    input  out_valid, out_data, out_last,
    input  busy, fin, timed_out, cycle_count
  );
endinterface

// File: rtl/run_host.sv
// Run controller: preload data memory, kick the core, time the run, drain a result window.
module run_host #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  run_host_if.master bus
);
  localparam int unsigned   RW       = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KICK  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= AW'(0);
      rem_q   <= RW'(0);
      cnt_q   <= CW'(0);
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Next state plus read window, cycle counter and timeout flag
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ptr_d   = bus.rd_base;
          rem_d   = bus.rd_len;
          cnt_d   = CW'(0);
          to_d    = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // ld_ready is high throughout LOAD, so valid alone means accepted
        if (bus.ld_valid && bus.ld_last) state_d = S_KICK;
      end
      S_KICK: begin
        cnt_d   = CW'(0);
        state_d = S_RUN;
      end
      S_RUN: begin
        // done takes priority over a coincident timeout
        if (bus.core_done) begin
          state_d = S_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          to_d    = 1'b1;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (rem_q == RW'(0)) begin
          state_d = S_FIN;
        end else if (bus.out_ready) begin
          ptr_d = ptr_q + AW'(1);
          rem_d = rem_q - RW'(1);
          if (rem_q == RW'(1)) state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; memory port and result stream pass through combinationally
  always_comb begin
    bus.ld_ready    = 1'b0;
    bus.core_hold   = 1'b1;
    bus.core_req    = 1'b0;
    bus.mem_sel     = 1'b1;
    bus.mem_wr_en   = 1'b0;
    bus.mem_addr    = AW'(0);
    bus.mem_wdata   = DW'(0);
    bus.out_valid   = 1'b0;
    bus.out_data    = DW'(0);
    bus.out_last    = 1'b0;
    bus.fin         = 1'b0;
    bus.busy        = (state_q != S_IDLE);
    bus.timed_out   = to_q;
    bus.cycle_count = cnt_q;
    case (state_q)
      S_LOAD: begin
        bus.ld_ready  = 1'b1;
        bus.mem_wr_en = bus.ld_valid;
        bus.mem_addr  = bus.ld_addr;
        bus.mem_wdata = bus.ld_data;
      end
      S_KICK: begin
        bus.core_hold = 1'b0;
        bus.mem_sel   = 1'b0;
        bus.core_req  = 1'b1;
      end
      S_RUN: begin
        bus.core_hold = 1'b0;
        bus.mem_sel   = 1'b0;
      end
      S_DRAIN: begin
        bus.mem_addr  = ptr_q;
        bus.out_valid = (rem_q != RW'(0));
        bus.out_data  = bus.mem_rdata;
        bus.out_last  = (rem_q == RW'(1));
      end
      S_FIN:   bus.fin = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_run_host.sv
// Directed bench for run_host: table of runs plus reset-abort and ignored-input sequences.
module tb_run_host;
  logic clk;
  logic reset;

  run_host_if #(.AW(8), .DW(8), .CW(16)) bus ();

  run_host #(.AW(8), .DW(8), .CW(16), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: data memory, core stub, monitors
  logic [7:0] tb_mem [256];
  int         ctr        = 0;
  int         done_dly   = 0;
  logic       force_done = 1'b0;

  always @(posedge clk)
    if (bus.mem_sel && bus.mem_wr_en) tb_mem[bus.mem_addr] <= bus.mem_wdata;

  assign bus.mem_rdata = tb_mem[bus.mem_addr];

  // Core stub: done rises done_dly cycles after the req cycle, 0 = never
  always @(posedge clk) begin
    if (bus.core_req)       ctr <= 1;
    else if (bus.core_hold) ctr <= 0;
    else if (ctr != 0)      ctr <= ctr + 1;
  end
  assign bus.core_done = force_done | ((done_dly != 0) && (ctr >= done_dly));

  int         wr_cnt    = 0;
  int         req_cnt   = 0;
  int         fin_cnt   = 0;
  int         stall_obs = 0;
  int         stall_err = 0;
  logic       prev_v    = 1'b0;
  logic       prev_r    = 1'b0;
  logic [7:0] prev_d    = 8'h00;
  logic [7:0] out_d_q [$];
  logic       out_l_q [$];

  always @(negedge clk) begin
    if (bus.mem_sel && bus.mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (bus.core_req) req_cnt <= req_cnt + 1;
    if (bus.fin) fin_cnt <= fin_cnt + 1;
    if (bus.out_valid && bus.out_ready) begin
      out_d_q.push_back(bus.out_data);
      out_l_q.push_back(bus.out_last);
    end
    if (prev_v && !prev_r) begin
      stall_obs <= stall_obs + 1;
      if (!(bus.out_valid && (bus.out_data == prev_d))) stall_err <= stall_err + 1;
    end
    prev_v <= bus.out_valid;
    prev_r <= bus.out_ready;
    prev_d <= bus.out_data;
  end

  // Checking
  int n_cmp  = 0;
  int n_bad  = 0;
  int tcount = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcount++;
  endtask

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    int          nld;
    int          dly;
    logic [3:0]  pat;
    logic [15:0] cc;
    logic        to;
    int          lat;
    int          stalls;
  } vec_t;

  vec_t vt [8];

  task automatic wait_idle(input logic [3:0] pat, output int guard);
    int k;
    k = 0;
    guard = 0;
    while (bus.busy && guard < 300) begin
      if (bus.out_valid) begin
        bus.out_ready = pat[k % 4];
        k++;
      end else begin
        bus.out_ready = 1'b1;
      end
      tick();
      guard++;
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int base_q, w0, r0, f0, s0, t0, guard;
    base_q   = out_d_q.size();
    w0       = wr_cnt;
    r0       = req_cnt;
    f0       = fin_cnt;
    s0       = stall_obs;
    done_dly = v.dly;
    bus.rd_base = v.base;
    bus.rd_len  = v.len;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.rd_base = ~v.base;
    bus.rd_len  = 9'h1FF;
    t0 = tcount;
    chk($sformatf("v%0d_ld_ready", vi), 32'(bus.ld_ready), 32'd1);
    chk($sformatf("v%0d_to_clear", vi), 32'(bus.timed_out), 32'd0);
    chk($sformatf("v%0d_cc_clear", vi), 32'(bus.cycle_count), 32'd0);
    for (int i = 0; i < v.nld; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = v.base + 8'(i);
      bus.ld_data  = 8'(8'h11 * (i + 1) + vi);
      bus.ld_last  = (i == v.nld - 1);
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    chk($sformatf("v%0d_req", vi), 32'(bus.core_req), 32'd1);
    wait_idle(v.pat, guard);
    chk($sformatf("v%0d_bound", vi), 32'(guard < 300), 32'd1);
    chk($sformatf("v%0d_latency", vi), 32'(tcount - t0), 32'(v.lat));
    chk($sformatf("v%0d_writes", vi), 32'(wr_cnt - w0), 32'(v.nld));
    chk($sformatf("v%0d_req_pulses", vi), 32'(req_cnt - r0), 32'd1);
    chk($sformatf("v%0d_fin_pulses", vi), 32'(fin_cnt - f0), 32'd1);
    chk($sformatf("v%0d_cycle_count", vi), 32'(bus.cycle_count), 32'(v.cc));
    chk($sformatf("v%0d_timed_out", vi), 32'(bus.timed_out), 32'(v.to));
    chk($sformatf("v%0d_stalls", vi), 32'(stall_obs - s0), 32'(v.stalls));
    chk($sformatf("v%0d_words", vi), 32'(out_d_q.size() - base_q), 32'(v.len));
    for (int j = 0; j < int'(v.len); j++) begin
      if (base_q + j < out_d_q.size()) begin
        chk($sformatf("v%0d_data%0d", vi, j), 32'(out_d_q[base_q + j]), 32'(8'(8'h11 * (j + 1) + vi)));
        chk($sformatf("v%0d_last%0d", vi, j), 32'(out_l_q[base_q + j]), 32'(j == int'(v.len) - 1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0, base_q, guard;

    //            base    len    nld dly pat    cc      to    lat stalls
    vt[0] = '{8'h00, 9'd3, 3, 10, 4'hF, 16'd9,  1'b0, 18, 0};
    vt[1] = '{8'h40, 9'd2, 2, 1,  4'hF, 16'd0,  1'b0, 7,  0};
    vt[2] = '{8'hFE, 9'd3, 3, 5,  4'hF, 16'd4,  1'b0, 13, 0};
    vt[3] = '{8'h10, 9'd4, 4, 0,  4'hF, 16'd15, 1'b1, 26, 0};
    vt[4] = '{8'h20, 9'd4, 4, 3,  4'h9, 16'd2,  1'b0, 17, 4};
    vt[5] = '{8'h30, 9'd0, 1, 1,  4'hF, 16'd0,  1'b0, 5,  0};
    vt[6] = '{8'h50, 9'd1, 1, 16, 4'hF, 16'd15, 1'b0, 20, 0};
    vt[7] = '{8'h60, 9'd1, 1, 15, 4'hF, 16'd14, 1'b0, 19, 0};

    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.rd_base   = 8'h00;
    bus.rd_len    = 9'd0;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = 8'h00;
    bus.ld_data   = 8'h00;
    bus.ld_last   = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    chk("rst_hold_sel", 32'({bus.core_hold, bus.mem_sel}), 32'h3);
    chk("rst_ctl", 32'({bus.ld_ready, bus.core_req, bus.mem_wr_en, bus.out_valid,
                        bus.out_last, bus.fin, bus.busy, bus.timed_out}), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_cycle_count", 32'(bus.cycle_count), 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    for (int vi = 0; vi < 8; vi++) run_vec(vi, vt[vi]);

    // start during RUN and done during LOAD are both ignored
    r0 = req_cnt;
    f0 = fin_cnt;
    base_q = out_d_q.size();
    done_dly    = 4;
    bus.rd_base = 8'h70;
    bus.rd_len  = 9'd2;
    bus.start   = 1'b1;
    tick();
    bus.start  = 1'b0;
    force_done = 1'b1;
    tick();
    tick();
    chk("ign_busy_load", 32'(bus.busy), 32'd1);
    chk("ign_hold_load", 32'(bus.core_hold), 32'd1);
    chk("ign_req_load", 32'(bus.core_req), 32'd0);
    chk("ign_ld_ready", 32'(bus.ld_ready), 32'd1);
    force_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 8'h70 + 8'(i);
      bus.ld_data  = 8'hA1 + 8'(i);
      bus.ld_last  = (i == 1);
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    tick();
    bus.start   = 1'b1;
    bus.rd_base = 8'h00;
    bus.rd_len  = 9'd1;
    tick();
    bus.start = 1'b0;
    wait_idle(4'hF, guard);
    chk("ign_bound", 32'(guard < 300), 32'd1);
    chk("ign_req_pulses", 32'(req_cnt - r0), 32'd1);
    chk("ign_fin_pulses", 32'(fin_cnt - f0), 32'd1);
    chk("ign_cycle_count", 32'(bus.cycle_count), 32'd3);
    chk("ign_words", 32'(out_d_q.size() - base_q), 32'd2);
    if (out_d_q.size() >= base_q + 2) begin
      chk("ign_data0", 32'(out_d_q[base_q]), 32'hA1);
      chk("ign_data1", 32'(out_d_q[base_q + 1]), 32'hA2);
    end
    tick();
    tick();
    chk("ign_stays_idle", 32'(bus.busy), 32'd0);

    // asynchronous reset in the middle of RUN
    f0 = fin_cnt;
    base_q = out_d_q.size();
    done_dly    = 0;
    bus.rd_base = 8'h10;
    bus.rd_len  = 9'd1;
    bus.start   = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 8'h10;
    bus.ld_data  = 8'h5C;
    bus.ld_last  = 1'b1;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    tick();
    tick();
    tick();
    chk("arst_in_run", 32'({bus.core_hold, bus.mem_sel, bus.busy}), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_hold", 32'(bus.core_hold), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ctl", 32'({bus.core_req, bus.out_valid, bus.fin, bus.ld_ready}), 32'h0);
    chk("arst_cc", 32'(bus.cycle_count), 32'h0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("arst_no_fin", 32'(fin_cnt - f0), 32'd0);
    chk("arst_idle", 32'(bus.busy), 32'd0);
    chk("arst_no_words", 32'(out_d_q.size() - base_q), 32'd0);
    chk("stall_integrity", 32'(stall_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/run_host.md
# run_host

Host-side run controller that drives the core's `req`/`done` handshake from the opposite end. It preloads the core's data memory through a valid/ready load stream, holds the core in reset until the load completes, then pulses `req`. It waits for `done` (or a timeout) while counting cycles, and finally drains a result window from data memory out through a valid/ready stream. It sits between the bench or host and the processor top level, and owns the data-memory port whenever the core is held.

## Interface
- `AW`, 8: data-memory address width
- `DW`, 8: data-memory word width
- `CW`, 16: cycle-counter width
- `TIMEOUT`, 4096: run cycles allowed before abort; must be ≤ 2^CW − 1
- `clk` in 1: single clock; all state on rising edge
- `reset` in 1: asynchronous, active-low; forces IDLE
- `start` in 1: begin a run; sampled only in IDLE
- `rd_base` in AW: first result address; captured on `start`
- `rd_len` in AW+1: number of result words; captured on `start`
- `ld_valid` in 1: load word valid
- `ld_addr` in AW: load address
- `ld_data` in DW: load data
- `ld_last` in 1: final load word
- `ld_ready` out 1: load accepted when `ld_valid & ld_ready`
- `core_hold` out 1: reset to the core, active-high
- `core_req` out 1: run request to the core
- `core_done` in 1: level done from the core
- `mem_sel` out 1: 1 = host owns the data-memory port
- `mem_wr_en` out 1: memory write enable
- `mem_addr` out AW: memory address
- `mem_wdata` out DW: memory write data
- `mem_rdata` in DW: memory read data, combinational from `mem_addr`
- `out_valid` out 1: result word valid
- `out_data` out DW: result word
- `out_last` out 1: final result word
- `out_ready` in 1: downstream accept
- `busy` out 1: state ≠ IDLE
- `fin` out 1: one-cycle pulse at end of run
- `timed_out` out 1: last run hit TIMEOUT; held until next `start`
- `cycle_count` out CW: cycles from `req` to `done`; held until next `start`

## Operation
- States: IDLE → LOAD → KICK → RUN → DRAIN → FIN → IDLE.
- IDLE:
  - `core_hold`=1, `mem_sel`=1.
  - On `start`: capture `rd_base`/`rd_len`, clear `cycle_count` and `timed_out`, go to LOAD.
- LOAD:
  - `ld_ready`=1.
  - `mem_wr_en`=`ld_valid`, `mem_addr`=`ld_addr`, `mem_wdata`=`ld_data`, all combinational; the write commits at the next edge.
  - An accepted word with `ld_last`=1 moves to KICK. That word is still written.
- KICK (1 cycle):
  - `core_hold`=0, `mem_sel`=0, `core_req`=1.
  - `cycle_count`←0.
- RUN:
  - `mem_sel`=0, `core_hold`=0, `core_req`=0.
  - `cycle_count` increments by 1 each cycle.
  - If `core_done`=1: freeze `cycle_count` and go to DRAIN.
  - Else if `cycle_count`=TIMEOUT−1: set `timed_out` and go to DRAIN.
  - If done and timeout occur in the same cycle, done wins and `timed_out` stays 0.
- DRAIN:
  - `core_hold`=1, `mem_sel`=1.
  - Read pointer starts at the captured `rd_base`; `mem_addr`=pointer.
  - `out_valid`=1, `out_data`=`mem_rdata`.
  - `out_last`=1 when remaining count = 1.
  - On `out_valid & out_ready`: pointer+1 (wraps mod 2^AW) and remaining−1.
  - After the last word is accepted, go to FIN.
  - If `rd_len`=0, go straight to FIN with no `out_valid`.
- FIN: `fin`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- `core_done` is ignored outside RUN.

## Timing
- Reset values:
  - Asserted: `core_hold`=1, `mem_sel`=1.
  - Deasserted: `ld_ready`, `core_req`, `mem_wr_en`, `out_valid`, `out_last`, `fin`, `busy`, `timed_out` all 0.
  - Zero: `mem_addr`, `mem_wdata`, `out_data`, `cycle_count`.
- Reset asserted mid-run aborts immediately: core held, streams dropped, no `fin`.
- `start` to `ld_ready`: 1 cycle.
- Last load accept to `core_req`: 1 cycle. `core_req` is high exactly 1 cycle.
- `cycle_count` equals the number of RUN cycles before the cycle in which `core_done` is sampled high.
  - Example: done high on the first RUN cycle gives 0.
- DRAIN read latency is 0: `out_data` is valid in the same cycle as `mem_addr`.
- `out_valid` never drops without an accept.
- Sustained throughput: 1 load word per cycle and 1 result word per cycle.
- Minimum run, IDLE back to IDLE with 1 load word, done on the first RUN cycle, `rd_len`=0: 5 cycles after `start`.

## Test plan
- Load 3 words (addr 0,1,2 = 0x11,0x22,0x33, last on the third). Core stub raises done 10 cycles after `req`. `rd_base`=0, `rd_len`=3, `out_ready`=1. Expected:
  - 3 writes.
  - One `core_req` pulse.
  - `cycle_count`=9.
  - Outputs 0x11,0x22,0x33 with `out_last` on 0x33.
  - `fin` pulse.
- Core never raises done, TIMEOUT=16 → `timed_out`=1, `cycle_count`=15, drain still occurs.
- `rd_base`=0xFE, `rd_len`=3 → reads 0xFE, 0xFF, 0x00 (wrap).
- `out_ready` toggles 1,0,0,1,… → `out_data` and `out_valid` are stable while stalled, and no word is duplicated or skipped.
- `reset` pulled low during RUN → `core_hold`=1, state IDLE, no `fin`, `busy`=0 asynchronously.
- `start` pulsed during RUN and `core_done` held high during LOAD → both ignored; `core_req` is still a single pulse.
